wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the pipeline.
//
// Non-load instructions write the register file one cycle after they are
// accepted. Loads move to WAIT and hold upstream (freeze) until memory
// returns data or TIMEOUT wait cycles pass. On a timeout the write is
// dropped and err pulses for one cycle.
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous reset, active low
//   in_valid         upstream presents an instruction
//   in_wb_en         instruction writes the register file
//   in_mem_r_en      instruction is a load
//   in_dest          destination register index
//   in_alu_result    ALU result for non-loads
//   mem_rdata_valid  load data returned this cycle
//   mem_rdata        load data
//   freeze           stall request to upstream (state == WAIT)
//   wb_wb_en         register-file write enable (single-cycle pulse)
//   wb_dest          register-file write index (held between writes)
//   wb_value         register-file write data (held between writes)
//   err              single-cycle pulse: load timed out, write dropped
module wb_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_wb_en,
  input  logic        in_mem_r_en,
  input  logic [3:0]  in_dest,
  input  logic [31:0] in_alu_result,
  input  logic        mem_rdata_valid,
  input  logic [31:0] mem_rdata,
  output logic        freeze,
  output logic        wb_wb_en,
  output logic [3:0]  wb_dest,
  output logic [31:0] wb_value,
  output logic        err
);

  localparam int DATA_W = 32;
  localparam int DEST_W = 4;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                cap_p0;
  logic                wb_en_p1;
  logic [DEST_W-1:0]   dest_p1;
  logic                wr_en_p0;
  logic [DEST_W-1:0]   wr_dest_p0;
  logic [DATA_W-1:0]   wr_value_p0;
  logic                err_p0;

  // freeze comes straight from the state register
  assign freeze = (state_q == WAIT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_p0      = 1'b0;
    wr_en_p0    = 1'b0;
    wr_dest_p0  = in_dest;
    wr_value_p0 = in_alu_result;
    err_p0      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_mem_r_en) begin
            state_d = WAIT;
            cnt_d   = 8'd0;
            cap_p0  = 1'b1;
          end else begin
            wr_en_p0 = in_wb_en;
          end
        end
      end
      WAIT: begin
        // returning data wins over the timeout in the final wait cycle
        if (mem_rdata_valid) begin
          wr_en_p0    = wb_en_p1;
          wr_dest_p0  = dest_p1;
          wr_value_p0 = mem_rdata;
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_p0  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // p0 -> p1: capture load destination and write enable while waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_p1 <= 1'b0;
      dest_p1  <= '0;
    end else if (cap_p0) begin
      wb_en_p1 <= in_wb_en;
      dest_p1  <= in_dest;
    end
  end

  // p0 -> output: write-back registers; index/data hold unless writing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wb_en <= 1'b0;
      err      <= 1'b0;
      wb_dest  <= '0;
      wb_value <= '0;
    end else begin
      wb_wb_en <= wr_en_p0;
      err      <= err_p0;
      if (wr_en_p0) begin
        wb_dest  <= wr_dest_p0;
        wb_value <= wr_value_p0;
      end
    end
  end

endmodule
